// File: rtl/inst_perf_cnt_if.sv
// Snapshot read channel of inst_perf_cnt: request/index/ack from the consumer,
// ready/valid/data/error back from the counter block.
interface inst_perf_cnt_if #(
    parameter int NUM_CLASS = 4,
    parameter int CNT_W     = 16,
    parameter int IW        = $clog2(NUM_CLASS + 1)
);
    logic             rd_req;
    logic [IW-1:0]    rd_idx;
    logic             rd_ack;
    logic             rd_ready;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic             rd_err;

    modport master (
        output rd_req, rd_idx, rd_ack,
        input  rd_ready, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  rd_req, rd_idx, rd_ack,
        output rd_ready, rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/inst_perf_cnt.sv
// Per-class retired-instruction and stall-cycle counters with sticky overflow,
// a snapshot bank and a single-entry request/hold read port.
module inst_perf_cnt #(
    parameter int NUM_CLASS = 4,
    parameter int CNT_W     = 16,
    parameter int SAT_MODE  = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             retire_valid,
    input  logic [$clog2(NUM_CLASS+1)-1:0]   retire_class,
    input  logic                             stall,
    input  logic                             clear,
    input  logic                             snap,
    output logic [NUM_CLASS:0]               ovf,
    inst_perf_cnt_if.slave                   rd
);
    localparam int IW = $clog2(NUM_CLASS + 1);
    localparam int NC = NUM_CLASS + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [CNT_W-1:0]   live_q [NC];
    logic [CNT_W-1:0]   live_d [NC];
    logic [CNT_W-1:0]   snap_q [NC];
    logic [NUM_CLASS:0] ovf_q, ovf_d;
    logic [NC-1:0]      inc;

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   data_q, data_d;
    logic               err_q, err_d;

    // Classes >= NUM_CLASS never match a class slot, so they count nowhere.
    always_comb begin
        inc = '0;
        for (int unsigned i = 0; i < NUM_CLASS; i++) begin
            inc[i] = retire_valid && (retire_class == IW'(i));
        end
        inc[NUM_CLASS] = stall;
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int unsigned i = 0; i < NC; i++) begin
            live_d[i] = live_q[i];
            if (inc[i]) begin
                if (&live_q[i]) begin
                    ovf_d[i]  = 1'b1;
                    live_d[i] = (SAT_MODE != 0) ? '1 : '0;
                end else begin
                    live_d[i] = live_q[i] + CNT_W'(1);
                end
            end
        end
        if (clear) begin
            ovf_d = '0;
            for (int unsigned i = 0; i < NC; i++) begin
                live_d[i] = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (rd.rd_req) begin
                    state_d = HOLD;
                    err_d   = (rd.rd_idx > IW'(NUM_CLASS));
                    data_d  = '0;
                    for (int unsigned i = 0; i < NC; i++) begin
                        if (rd.rd_idx == IW'(i)) data_d = snap_q[i];
                    end
                end
            end
            default: begin
                if (rd.rd_ack) state_d = IDLE;
            end
        endcase
    end

    // The bank samples live_q, i.e. the value before this edge's update or clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q  <= '{default: '0};
            snap_q  <= '{default: '0};
            ovf_q   <= '0;
            state_q <= IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            live_q  <= live_d;
            ovf_q   <= ovf_d;
            if (snap) snap_q <= live_q;
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign ovf         = ovf_q;
    assign rd.rd_ready = (state_q == IDLE);
    assign rd.rd_valid = (state_q == HOLD);
    assign rd.rd_data  = data_q;
    assign rd.rd_err   = err_q;
endmodule
